// File: rtl/pixel_collector_if.sv
// ============================================================================
// pixel_collector_if : iterator result / frame-buffer write bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pixel_collector_if #(
  parameter int ADDR_W = 19
) ();
  logic              iter_done;
  logic [31:0]       iterations;
  logic              all_done;
  logic [31:0]       max_iterations;
  logic              mem_ready;
  logic              handshake;
  logic              pixel_we;
  logic [ADDR_W-1:0] pixel_addr;
  logic [7:0]        pixel_color;
  logic              frame_done;
  logic [ADDR_W-1:0] inset_count;

  // Driver side: iterator and frame-buffer environment
  modport master (
    output iter_done, iterations, all_done, max_iterations, mem_ready,
    input  handshake, pixel_we, pixel_addr, pixel_color, frame_done, inset_count
  );

  // Collector side
  modport slave (
    input  iter_done, iterations, all_done, max_iterations, mem_ready,
    output handshake, pixel_we, pixel_addr, pixel_color, frame_done, inset_count
  );
endinterface

`default_nettype wire

// File: rtl/pixel_collector.sv
// ============================================================================
// pixel_collector : maps iterator results to RGB332 pixels written in raster
// order. Optional in-set histogram counter: PIXEL_COLLECTOR_HIST_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_collector #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  pixel_collector_if.slave  bus
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] C_X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_ACK       = 3'd2,
    S_WAIT_DROP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        color_q, color_d;
  logic              we_q, we_d;
  logic              frame_done_q, frame_done_d;
  logic              last_pixel;

  // First matching threshold wins; all comparisons unsigned 32-bit
  function automatic logic [7:0] colour_of(input logic [31:0] it, input logic [31:0] mx);
    if (it >= mx)             return 8'h00;
    else if (it >= (mx >> 1)) return 8'hE0;
    else if (it >= (mx >> 2)) return 8'hFC;
    else if (it >= (mx >> 3)) return 8'h1C;
    else if (it >= (mx >> 4)) return 8'h1F;
    else if (it >= (mx >> 5)) return 8'h03;
    else if (it >= (mx >> 6)) return 8'h63;
    else if (it >= (mx >> 7)) return 8'h6F;
    else                      return 8'h92;
  endfunction

  assign last_pixel = (x_q == C_X_LAST) && (y_q == C_Y_LAST);

`ifdef PIXEL_COLLECTOR_HIST_EN
  logic              in_set_q, in_set_d;
  logic [ADDR_W-1:0] inset_q, inset_d;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    color_d      = color_q;
    we_d         = we_q;
    frame_done_d = frame_done_q;
`ifdef PIXEL_COLLECTOR_HIST_EN
    in_set_d     = in_set_q;
    inset_d      = inset_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A pending result always takes priority over all_done
        if (bus.iter_done) begin
          color_d = colour_of(bus.iterations, bus.max_iterations);
          we_d    = 1'b1;
          state_d = S_WRITE;
`ifdef PIXEL_COLLECTOR_HIST_EN
          in_set_d = (bus.iterations >= bus.max_iterations);
`endif
        end else if (bus.all_done) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          we_d    = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        addr_d = addr_q + 1'b1;
        if (x_q == C_X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
`ifdef PIXEL_COLLECTOR_HIST_EN
        if (in_set_q && (inset_q != {ADDR_W{1'b1}})) begin
          inset_d = inset_q + 1'b1;
        end
`endif
        if (last_pixel) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          state_d = S_WAIT_DROP;
        end
      end
      S_WAIT_DROP: begin
        if (!bus.iter_done) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        we_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PIXEL_COLLECTOR_HIST_EN
      in_set_q     <= 1'b0;
      inset_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      color_q      <= color_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
`ifdef PIXEL_COLLECTOR_HIST_EN
      in_set_q     <= in_set_d;
      inset_q      <= inset_d;
`endif
    end
  end

  assign bus.handshake   = (state_q == S_ACK);
  assign bus.pixel_we    = we_q;
  assign bus.pixel_addr  = addr_q;
  assign bus.pixel_color = color_q;
  assign bus.frame_done  = frame_done_q;
`ifdef PIXEL_COLLECTOR_HIST_EN
  assign bus.inset_count = inset_q;
`else
  assign bus.inset_count = '0;
`endif

endmodule

`default_nettype wire
